// File: rtl/pll_lock_seq_clken.sv
`default_nettype none
// ============================================================================
// Module  : pll_lock_seq_clken
// Brief   : Post-PLL lock qualifier, stretched reset sequencer and
//           fractional clock-enable generator (PLL clock domain).
// Rev     : 1.0
// ============================================================================
module pll_lock_seq_clken #(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 24,
  parameter int LOCK_SYNC   = 2,
  parameter int LOCK_FILTER = 16,
  parameter int RST_HOLD    = 1024
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      pll_locked,
  input  logic                      run,
  input  logic [CHANNELS*ACC_W-1:0] inc,
  output logic                      rst_out_n,
  output logic                      ready,
  output logic [CHANNELS-1:0]       clk_en,
  output logic [7:0]                lock_lost_cnt
);

  localparam int CNT_MAX = (LOCK_FILTER > RST_HOLD) ? LOCK_FILTER : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_FILT_DONE = CNT_W'(LOCK_FILTER);
  localparam logic [CNT_W-1:0] c_HOLD_DONE = CNT_W'(RST_HOLD - 1);

  localparam logic [1:0] c_ST_WAIT   = 2'd0;
  localparam logic [1:0] c_ST_STABLE = 2'd1;
  localparam logic [1:0] c_ST_HOLD   = 2'd2;
  localparam logic [1:0] c_ST_RUN    = 2'd3;

  logic [LOCK_SYNC-1:0] r_sync;
  logic                 w_lk;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_in_run;
  logic                 r_rst_out_n;
  logic                 r_ready;
  logic [7:0]           r_lost;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[LOCK_SYNC-2:0], pll_locked};
    end
  end

  assign w_lk = r_sync[LOCK_SYNC-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_ST_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // One shared counter: filter length in STABLE, stretch length in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_WAIT: begin
        if (w_lk) begin
          w_state_nxt = c_ST_STABLE;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      c_ST_STABLE: begin
        if (!w_lk) begin
          w_state_nxt = c_ST_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_FILT_DONE) begin
          w_state_nxt = c_ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      c_ST_HOLD: begin
        if (!w_lk) begin
          w_state_nxt = c_ST_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_HOLD_DONE) begin
          w_state_nxt = c_ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      c_ST_RUN: begin
        if (!w_lk) begin
          w_state_nxt = c_ST_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = c_ST_WAIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_in_run = (r_state == c_ST_RUN);
  end

  // Outputs follow the state register by one cycle, so a RUN exit is seen
  // downstream together with the cleared enables and the bumped counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rst_out_n <= 1'b0;
      r_ready     <= 1'b0;
      r_lost      <= 8'd0;
    end else begin
      r_rst_out_n <= w_in_run;
      r_ready     <= w_in_run;
      if (r_ready && !w_in_run && (r_lost != 8'hFF)) begin
        r_lost <= r_lost + 8'd1;
      end
    end
  end

  assign rst_out_n     = r_rst_out_n;
  assign ready         = r_ready;
  assign lock_lost_cnt = r_lost;

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [ACC_W-1:0] r_acc;
      logic             r_en;
      logic [ACC_W:0]   w_sum;

      assign w_sum = {1'b0, r_acc} + {1'b0, inc[k*ACC_W +: ACC_W]};

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_acc <= '0;
          r_en  <= 1'b0;
        end else if (!w_in_run) begin
          r_acc <= '0;
          r_en  <= 1'b0;
        end else if (run) begin
          r_acc <= w_sum[ACC_W-1:0];
          r_en  <= w_sum[ACC_W];
        end else begin
          r_en  <= 1'b0;
        end
      end

      assign clk_en[k] = r_en;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_seq_clken.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_pll_lock_seq_clken
// Brief   : Self-checking bench: default-size instance for exact latencies,
//           small-filter instance for saturation and randomized traffic.
// Rev     : 1.0
// ============================================================================
module tb_pll_lock_seq_clken;

  localparam int T_A = 16 + 1024 + 1;
  localparam int T_B = 3 + 5 + 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a = 1'b0, pll_a = 1'b0, run_a = 1'b0;
  logic [47:0] inc_a = '0;
  logic        rst_a, rdy_a;
  logic [1:0]  en_a;
  logic [7:0]  cnt_a;

  logic        rstn_b = 1'b0, pll_b = 1'b0, run_b = 1'b0;
  logic [47:0] inc_b = '0;
  logic        rst_b, rdy_b;
  logic [1:0]  en_b;
  logic [7:0]  cnt_b;

  pll_lock_seq_clken u_dut_a (
    .clk(clk), .resetn(rstn_a), .pll_locked(pll_a), .run(run_a), .inc(inc_a),
    .rst_out_n(rst_a), .ready(rdy_a), .clk_en(en_a), .lock_lost_cnt(cnt_a)
  );

  pll_lock_seq_clken #(.CHANNELS(2), .ACC_W(24), .LOCK_SYNC(2), .LOCK_FILTER(3), .RST_HOLD(5)) u_dut_b (
    .clk(clk), .resetn(rstn_b), .pll_locked(pll_b), .run(run_b), .inc(inc_b),
    .rst_out_n(rst_b), .ready(rdy_b), .clk_en(en_b), .lock_lost_cnt(cnt_b)
  );

  // Reference: RUN is reached once the synced lock has been seen high on
  // T consecutive edges; everything else is plain arithmetic on that.
  typedef struct {
    logic [1:0] h;
    int         streak;
    logic       rdy;
    logic [1:0] en;
    int         cnt;
    int         acc0;
    int         acc1;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.h = 2'b00; m.streak = 0; m.rdy = 1'b0; m.en = 2'b00;
    m.cnt = 0; m.acc0 = 0; m.acc1 = 0;
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, logic p, logic r, logic [47:0] inc, int t);
    mdl_t n;
    logic was_run;
    int   s0, s1;
    n       = m;
    was_run = (m.streak >= t);
    n.h     = {m.h[0], p};
    n.rdy   = was_run;
    n.en    = 2'b00;
    if (!was_run) begin
      n.acc0 = 0;
      n.acc1 = 0;
    end else if (r) begin
      s0     = m.acc0 + int'(inc[23:0]);
      s1     = m.acc1 + int'(inc[47:24]);
      n.en   = {s1 >= (1 << 24), s0 >= (1 << 24)};
      n.acc0 = s0 % (1 << 24);
      n.acc1 = s1 % (1 << 24);
    end
    if (m.rdy && !was_run && m.cnt < 255) n.cnt = m.cnt + 1;
    if (m.h[1]) n.streak = (m.streak < t) ? m.streak + 1 : t;
    else        n.streak = 0;
    return n;
  endfunction

  mdl_t ma, mb;

  always @(posedge clk or negedge rstn_a) begin
    if (!rstn_a) ma <= mdl_reset();
    else         ma <= step(ma, pll_a, run_a, inc_a, T_A);
  end

  always @(posedge clk or negedge rstn_b) begin
    if (!rstn_b) mb <= mdl_reset();
    else         mb <= step(mb, pll_b, run_b, inc_b, T_B);
  end

  int n_chk = 0;
  int n_err = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("model_a", 32'({rst_a, rdy_a, en_a, cnt_a}), 32'({ma.rdy, ma.rdy, ma.en, 8'(ma.cnt)}));
      chk("model_b", 32'({rst_b, rdy_b, en_b, cnt_b}), 32'({mb.rdy, mb.rdy, mb.en, 8'(mb.cnt)}));
    end
  end

  typedef struct {
    logic        run;
    logic [23:0] inc0;
    logic [23:0] inc1;
    logic [1:0]  en;
  } vec_t;

  vec_t tbl [18];

  task automatic seq_a();
    tbl[0]  = '{1'b1, 24'h400000, 24'hC00000, 2'b00};
    tbl[1]  = '{1'b1, 24'h400000, 24'hC00000, 2'b10};
    tbl[2]  = '{1'b1, 24'h400000, 24'hC00000, 2'b10};
    tbl[3]  = '{1'b1, 24'h400000, 24'hC00000, 2'b11};
    tbl[4]  = '{1'b1, 24'h400000, 24'hC00000, 2'b00};
    tbl[5]  = '{1'b1, 24'h400000, 24'hC00000, 2'b10};
    tbl[6]  = '{1'b0, 24'h400000, 24'hC00000, 2'b00};
    tbl[7]  = '{1'b0, 24'h400000, 24'hC00000, 2'b00};
    tbl[8]  = '{1'b0, 24'h400000, 24'hC00000, 2'b00};
    tbl[9]  = '{1'b0, 24'h400000, 24'hC00000, 2'b00};
    tbl[10] = '{1'b0, 24'h400000, 24'hC00000, 2'b00};
    tbl[11] = '{1'b1, 24'h400000, 24'h000000, 2'b00};
    tbl[12] = '{1'b1, 24'h400000, 24'h000000, 2'b01};
    tbl[13] = '{1'b1, 24'h400000, 24'h000000, 2'b00};
    tbl[14] = '{1'b1, 24'h400000, 24'h000000, 2'b00};
    tbl[15] = '{1'b1, 24'h800000, 24'h000000, 2'b01};
    tbl[16] = '{1'b1, 24'h800000, 24'h000000, 2'b00};
    tbl[17] = '{1'b1, 24'h800000, 24'h000000, 2'b01};

    // Lock present from edge 0: release exactly at edge 1043.
    rstn_a = 1'b1;
    pll_a  = 1'b1;
    repeat (1043) @(negedge clk);
    chk("rst_edge1042", 32'({rst_a, rdy_a}), 32'd0);
    @(negedge clk);
    chk("rst_edge1043", 32'({rst_a, rdy_a, cnt_a}), 32'({2'b11, 8'd0}));

    for (int i = 0; i < 18; i++) begin
      run_a = tbl[i].run;
      inc_a = {tbl[i].inc1, tbl[i].inc0};
      @(negedge clk);
      chk($sformatf("clken_row%0d", i), 32'(en_a), 32'(tbl[i].en));
    end

    // Drop in RUN while channel 0 is one add away from overflowing.
    run_a = 1'b1;
    inc_a = {24'h0, 24'h400000};
    pll_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_edge2", 32'({rst_a, rdy_a}), 32'd3);
    @(negedge clk);
    chk("drop_edge3", 32'({rst_a, rdy_a, en_a, cnt_a}), 32'({4'b0000, 8'd1}));
    repeat (5) @(negedge clk);

    // Relock with a one-cycle glitch at edge 10: release moves to 1054.
    pll_a = 1'b1;
    repeat (10) @(negedge clk);
    pll_a = 1'b0;
    @(negedge clk);
    pll_a = 1'b1;
    repeat (1043) @(negedge clk);
    chk("glitch_edge1053", 32'(rst_a), 32'd0);
    @(negedge clk);
    chk("glitch_edge1054", 32'({rst_a, rdy_a, en_a, cnt_a}), 32'({4'b1100, 8'd1}));
    repeat (2) @(negedge clk);
    chk("relock_add3", 32'(en_a), 32'd0);
    @(negedge clk);
    chk("relock_add4", 32'(en_a), 32'd1);

    // Second drop, relock, then asynchronous reset in the middle of HOLD.
    pll_a = 1'b0;
    repeat (6) @(negedge clk);
    chk("lost_cnt_2", 32'(cnt_a), 32'd2);
    pll_a = 1'b1;
    repeat (600) @(negedge clk);
    chk("hold_rst_low", 32'({rst_a, rdy_a}), 32'd0);
    #2 rstn_a = 1'b0;
    #1 chk("async_reset", 32'({rst_a, rdy_a, en_a, cnt_a}), 32'd0);
    @(negedge clk);
    rstn_a = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic seq_b();
    logic [31:0] r0, r1;
    int          k;
    rstn_b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pll_b = 1'b1;
      k = 0;
      while (!rdy_b && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("b_lock_reached", 32'(rdy_b), 32'd1);
      pll_b = 1'b0;
      repeat (4) @(negedge clk);
      if (i == 0)   chk("lost_cnt_1", 32'(cnt_b), 32'd1);
      if (i == 254) chk("lost_cnt_255", 32'(cnt_b), 32'd255);
    end
    chk("lost_cnt_sat", 32'(cnt_b), 32'd255);

    for (int c = 0; c < 3000; c++) begin
      pll_b = ($urandom_range(99) < 96);
      run_b = ($urandom_range(99) < 80);
      if ($urandom_range(15) == 0) begin
        r0 = $urandom;
        r1 = $urandom;
        if (r0[31:29] == 3'd0) r0[23:0] = 24'd0;
        inc_b = {r1[23:0], r0[23:0]};
      end
      if ($urandom_range(999) == 0) begin
        #2 rstn_b = 1'b0;
        @(negedge clk);
        rstn_b = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_a", 32'({rst_a, rdy_a, en_a, cnt_a}), 32'd0);
    chk("reset_b", 32'({rst_b, rdy_b, en_b, cnt_b}), 32'd0);
    mon_on = 1'b1;
    fork
      seq_a();
      seq_b();
    join
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected completion by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_seq_clken.md
Name: pll_lock_seq_clken

Overview:
- Post-PLL clock manager that runs in the PLL output clock domain.
- Qualifies the asynchronous PLL lock flag and sequences a stretched synchronous reset for downstream logic.
- Generates CHANNELS independent fractional clock enables from per-channel phase increments, e.g. a 4.194304 MHz CPU enable derived from a 33.75 MHz PLL clock.
- Counts lock-loss events for debug.

Parameters:
- CHANNELS, 2, number of clock-enable channels (1..8).
- ACC_W, 24, phase accumulator width per channel, in bits.
- LOCK_SYNC, 2, synchroniser flops on pll_locked (min 2).
- LOCK_FILTER, 16, consecutive synced-high cycles required before lock is accepted (min 1).
- RST_HOLD, 1024, cycles rst_out_n is held low after lock is accepted (min 1).

Ports:
- clk  in  1  PLL output clock; all logic is in this domain.
- resetn  in  1  asynchronous active-low reset.
- pll_locked  in  1  raw PLL lock; asynchronous to clk.
- run  in  1  enables the accumulators while in RUN.
- inc  in  CHANNELS*ACC_W  per-channel phase increment; channel k occupies bits [k*ACC_W +: ACC_W].
- rst_out_n  out  1  synchronous active-low reset for downstream logic.
- ready  out  1  high only in RUN.
- clk_en  out  CHANNELS  one-cycle enable pulses.
- lock_lost_cnt  out  8  saturating count of lock drops from RUN.

Behaviour:
- Reset (resetn low): state=WAIT_LOCK, synchroniser=0, counters=0, accumulators=0. Outputs: rst_out_n=0, ready=0, clk_en=0, lock_lost_cnt=0.
- lk = output of the LOCK_SYNC-stage synchroniser on pll_locked.
- All outputs are registered.
- State WAIT_LOCK:
  - lk=1 → STABLE, with filter count=1.
- State STABLE:
  - lk=0 → WAIT_LOCK.
  - Else count++; when count reaches LOCK_FILTER → HOLD, with hold count=0.
- State HOLD:
  - rst_out_n stays 0; hold count++.
  - At RST_HOLD → RUN.
  - lk=0 → WAIT_LOCK.
- State RUN:
  - rst_out_n=1, ready=1, both asserted on the first RUN cycle.
  - lk=0 → WAIT_LOCK. On that edge: rst_out_n=0, ready=0, clk_en=0, accumulators cleared, lock_lost_cnt++ (saturates at 255, never wraps).
  - Lock drops from STABLE or HOLD do not count.
- Latency:
  - A pll_locked rise that meets setup at edge 0 gives rst_out_n=1 at edge LOCK_SYNC+LOCK_FILTER+RST_HOLD+1 (defaults: edge 1043).
  - A pll_locked fall in RUN gives rst_out_n=0 at edge LOCK_SYNC+1.
- Accumulators:
  - Per channel: {carry, acc_next} = acc + inc_k, computed ACC_W+1 bits wide.
  - Update only when state=RUN and run=1.
  - clk_en[k] register = carry; the pulse appears the cycle after the add that overflowed.
  - When not in RUN, or run=0: acc holds and clk_en=0. Exception: leaving RUN clears acc.
  - inc is sampled every cycle; a change affects the next add with no glitch or reset of phase.
  - inc=0: clk_en never pulses.
  - Long-run mean pulse rate = inc_k / 2^ACC_W of clk, exact to an ACC_W-bit fraction; no drift.
- Simultaneous events: lock drop and overflow in the same cycle → lock drop wins, so clk_en=0.
- Reset mid-operation: asynchronous reset returns to reset values immediately, regardless of state.

Test Plan:
- Reset, pll_locked=1 from edge 0, defaults → rst_out_n=0 through edge 1042 and 1 at edge 1043; ready rises at the same edge; lock_lost_cnt=0.
- pll_locked pulses low for 1 cycle at edge 10 → the STABLE count restarts; rst_out_n release is delayed by the corresponding number of cycles; no lock_lost increment.
- In RUN, ACC_W=24, inc0=0x400000, run=1 → clk_en[0] is high on every 4th cycle starting at the 4th add. inc1=0xC00000 → clk_en[1] pattern 0,1,1,1 repeating. inc1=0 → clk_en[1] stays 0.
- In RUN, drop pll_locked → rst_out_n=0 and ready=0 at LOCK_SYNC+1 edges; clk_en=0; lock_lost_cnt=1. Relock → full 1043-cycle sequence again; accumulators restart from 0.
- Force 300 RUN lock drops → lock_lost_cnt=255 and holds.
- run=0 for 5 cycles mid-sequence with inc0=0x400000 → pulses pause and resume with phase preserved, total pulses = (active adds)/4; assert resetn low mid-HOLD → all outputs return to reset values immediately.
